// File: rtl/rv32_pkg.sv
// Shared types and word constants for the RV32 memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv32_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    localparam logic [WORD_W-1:0] WORD_ZERO = '0;
    localparam logic [BE_W-1:0]   BE_NONE   = '0;
    localparam logic [BE_W-1:0]   BE_FULL   = '1;

    // Who the read data returning next cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_D_RD  = 2'd2
    } owner_e;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one always-ready single-port memory; data has priority.
// Latency: grant combinational in the request cycle; read data and rvalid one cycle after grant.
// Backpressure: a requester waits while its gnt is low; the memory side never stalls.
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   if_*                       fetch port (read only, with flush to discard an in-flight response)
//   d_*                        data port (read or byte-enabled write)
//   mem_*                      memory port, rdata valid one cycle after an accepted read
// Build option: define RV32_ARB_FAIRNESS_EN to let a waiting fetch win after STARVE_LIMIT
// consecutive data grants; without it the data port has strict priority.
module rv32_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [WORD_W-1:0] if_rdata_o,
    // data port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [BE_W-1:0]   d_be_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [WORD_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [WORD_W-1:0] d_rdata_o,
    // memory port
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i
);

    owner_e            owner_q, owner_d;
    logic              if_flush_q;     // flush level seen in the fetch grant cycle
    logic [WORD_W-1:0] if_hold_q;
    logic [WORD_W-1:0] d_hold_q;
    logic              d_win;
    logic              if_win;
    logic              fetch_due;      // fetch has waited long enough to beat data

`ifdef RV32_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign fetch_due = if_req_i && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Counts only data grants that happened over a waiting fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || if_win) begin
            starve_cnt_d = '0;
        end else if (d_win) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign fetch_due  = 1'b0;
    assign unused_cfg = ^STARVE_LIMIT;
`endif

    // Grants are held low during reset so nothing is accepted while rst_n_i is low.
    always_comb begin
        d_win  = rst_n_i && d_req_i && !fetch_due;
        if_win = rst_n_i && if_req_i && !d_win;
    end

    assign d_gnt_o  = d_win;
    assign if_gnt_o = if_win;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = BE_NONE;
        mem_addr_o  = '0;
        mem_wdata_o = WORD_ZERO;
        if (d_win) begin
            mem_req_o   = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_win) begin
            mem_req_o   = 1'b1;
            mem_be_o    = BE_FULL;
            mem_addr_o  = if_addr_i;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (if_win) begin
            owner_d = OWN_IF_RD;
        end else if (d_win && !d_we_i) begin
            owner_d = OWN_D_RD;
        end
    end

    // A flush in either the grant cycle or the return cycle kills the fetch response.
    assign if_rvalid_o = (owner_q == OWN_IF_RD) && !if_flush_q && !if_flush_i;
    assign d_rvalid_o  = (owner_q == OWN_D_RD);

    assign if_rdata_o = if_rvalid_o ? mem_rdata_i : if_hold_q;
    assign d_rdata_o  = d_rvalid_o  ? mem_rdata_i : d_hold_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_q    <= OWN_NONE;
            if_flush_q <= 1'b0;
            if_hold_q  <= WORD_ZERO;
            d_hold_q   <= WORD_ZERO;
        end else begin
            owner_q    <= owner_d;
            if_flush_q <= if_flush_i;
            if (if_rvalid_o) begin
                if_hold_q <= mem_rdata_i;
            end
            if (d_rvalid_o) begin
                d_hold_q <= mem_rdata_i;
            end
        end
    end

endmodule
